// File: rtl/lc3_pkg.sv
// Shared LC-3 constants: program-counter select encodings and default address-map values.
package lc3_pkg;

   localparam logic [1:0] PC_SEL_INC    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_SEL_TRAP   = 2'b11;

   localparam int          DEF_WIDTH        = 16;
   localparam logic [15:0] DEF_RESET_VECTOR = 16'h3000;
   localparam logic [15:0] DEF_TRAP_BASE    = 16'h0000;

endpackage

// File: rtl/pc_flush_ctr.sv
// Fetch-flush window counter: loads on a redirect, otherwise counts down to zero and stays there.
module pc_flush_ctr #(
   parameter int unsigned LOAD_VAL = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic nonzero
);

   localparam int unsigned    CW       = $clog2(LOAD_VAL + 1);
   localparam logic [CW-1:0]  LOAD_CNT = CW'(LOAD_VAL);

   logic [CW-1:0] cnt;

   // A reload mid-window restarts the count rather than adding to it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_CNT;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign nonzero = (cnt != '0);

endmodule

// File: rtl/pc_next_unit.sv
// LC-3 program-counter stage: PC register, next-PC selection, link capture and fetch-flush window.
module pc_next_unit
   import lc3_pkg::*;
#(
   parameter int               WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
   parameter bit               TRAP_EN      = 1'b1,
   parameter logic [WIDTH-1:0] TRAP_BASE    = WIDTH'(DEF_TRAP_BASE),
   parameter int               FLUSH_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       pc_sel,
   input  logic             advance,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic [WIDTH-1:0] jump_addr,
   input  logic [7:0]       trapvect,
   input  logic             link_req,
   input  logic             err_clr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_1,
   output logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] link_addr,
   output logic             link_valid,
   output logic             flush,
   output logic             sel_err
);

   logic illegal_sel;
   logic redirect;

   assign pc_plus_1   = pc + WIDTH'(1);
   assign illegal_sel = (pc_sel == PC_SEL_TRAP) && !TRAP_EN;
   assign redirect    = advance && (pc_sel != PC_SEL_INC) && !illegal_sel;

   // An illegal trap select resolves to the current pc so an advance simply holds.
   always_comb begin
      next_pc = pc;
      case (pc_sel)
         PC_SEL_INC:    next_pc = pc_plus_1;
         PC_SEL_BRANCH: next_pc = branch_addr;
         PC_SEL_JUMP:   next_pc = jump_addr;
         PC_SEL_TRAP:   next_pc = TRAP_EN ? {TRAP_BASE[WIDTH-1:8], trapvect} : pc;
         default:       next_pc = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VECTOR;
      end else if (advance) begin
         pc <= next_pc;
      end
   end

   // The link address is the return point of the instruction doing the redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_addr  <= '0;
         link_valid <= 1'b0;
      end else begin
         link_valid <= redirect && link_req;
         if (redirect && link_req) begin
            link_addr <= pc_plus_1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (advance && illegal_sel) begin
         sel_err <= 1'b1;
      end else if (err_clr) begin
         sel_err <= 1'b0;
      end
   end

   pc_flush_ctr #(
      .LOAD_VAL (FLUSH_CYCLES)
   ) u_flush_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (redirect),
      .nonzero (flush)
   );

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomised scoreboard bench for pc_next_unit: one trap-enabled instance and one trap-disabled, 3-cycle-flush instance.
module tb_pc_next_unit;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] pp1;
      logic [15:0] npc;
      logic [15:0] link;
      logic        lv;
      logic        fl;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  pc_sel = 2'b00;
   logic        advance = 1'b0;
   logic [15:0] branch_addr = '0;
   logic [15:0] jump_addr = '0;
   logic [7:0]  trapvect = '0;
   logic        link_req = 1'b0;
   logic        err_clr = 1'b0;

   logic [15:0] pc_a, pp1_a, npc_a, link_a;
   logic        lv_a, fl_a, err_a;
   logic [15:0] pc_b, pp1_b, npc_b, link_b;
   logic        lv_b, fl_b, err_b;

   int n_vec = 0;
   int n_bad = 0;

   // Model state, one slot per instance: [0] traps enabled / 1-cycle flush, [1] traps illegal / 3-cycle flush.
   int ten[2] = '{1, 0};
   int fcy[2] = '{1, 3};
   int m_pc[2];
   int m_link[2];
   int m_lv[2];
   int m_fl[2];
   int m_err[2];

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   pc_next_unit #(.WIDTH(16), .RESET_VECTOR(16'h3000), .TRAP_EN(1'b1),
                  .TRAP_BASE(16'h0000), .FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .advance(advance),
      .branch_addr(branch_addr), .jump_addr(jump_addr), .trapvect(trapvect),
      .link_req(link_req), .err_clr(err_clr),
      .pc(pc_a), .pc_plus_1(pp1_a), .next_pc(npc_a), .link_addr(link_a),
      .link_valid(lv_a), .flush(fl_a), .sel_err(err_a));

   pc_next_unit #(.WIDTH(16), .RESET_VECTOR(16'h3000), .TRAP_EN(1'b0),
                  .TRAP_BASE(16'h0000), .FLUSH_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .advance(advance),
      .branch_addr(branch_addr), .jump_addr(jump_addr), .trapvect(trapvect),
      .link_req(link_req), .err_clr(err_clr),
      .pc(pc_b), .pc_plus_1(pp1_b), .next_pc(npc_b), .link_addr(link_b),
      .link_valid(lv_b), .flush(fl_b), .sel_err(err_b));

   function automatic int target(input int d, input int cur);
      case (pc_sel)
         2'd0:    return (cur + 1) % 65536;
         2'd1:    return int'(branch_addr);
         2'd2:    return int'(jump_addr);
         default: return (ten[d] != 0) ? int'(trapvect) : cur;
      endcase
   endfunction

   task automatic model_reset(input int d);
      m_pc[d] = 'h3000; m_link[d] = 0; m_lv[d] = 0; m_fl[d] = 0; m_err[d] = 0;
   endtask

   task automatic model_step(input int d);
      int  tgt;
      bit  ill, redir;
      if (!rst_n) begin
         model_reset(d);
         return;
      end
      ill   = (pc_sel == 2'd3) && (ten[d] == 0);
      tgt   = target(d, m_pc[d]);
      redir = advance && (pc_sel != 2'd0) && !ill;
      m_lv[d] = (redir && link_req) ? 1 : 0;
      if (m_lv[d] != 0) m_link[d] = (m_pc[d] + 1) % 65536;
      m_fl[d] = redir ? fcy[d] : ((m_fl[d] > 0) ? m_fl[d] - 1 : 0);
      if (advance && ill) m_err[d] = 1;
      else if (err_clr)   m_err[d] = 0;
      if (advance) m_pc[d] = tgt;
   endtask

   function automatic exp_t make_exp(input int d);
      exp_t e;
      e.pc   = 16'(m_pc[d]);
      e.pp1  = 16'((m_pc[d] + 1) % 65536);
      e.npc  = 16'(target(d, m_pc[d]));
      e.link = 16'(m_link[d]);
      e.lv   = (m_lv[d] != 0);
      e.fl   = (m_fl[d] != 0);
      e.err  = (m_err[d] != 0);
      return e;
   endfunction

   task automatic push_exp();
      q0.push_back(make_exp(0));
      q1.push_back(make_exp(1));
   endtask

   task automatic cyc(input logic r, input logic [1:0] s, input logic a,
                      input logic [15:0] b, input logic [15:0] j, input logic [7:0] t,
                      input logic l, input logic e);
      @(negedge clk);
      rst_n = r; pc_sel = s; advance = a; branch_addr = b; jump_addr = j;
      trapvect = t; link_req = l; err_clr = e;
      model_step(0);
      model_step(1);
      push_exp();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0);
   endtask

   task automatic cmp(input string name, input int d, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, req);
      end
   endtask

   task automatic check_dut(input int d, input exp_t e);
      if (d == 0) begin
         cmp("pc", d, pc_a, e.pc);          cmp("pc_plus_1", d, pp1_a, e.pp1);
         cmp("next_pc", d, npc_a, e.npc);   cmp("link_addr", d, link_a, e.link);
         cmp("link_valid", d, 16'(lv_a), 16'(e.lv));
         cmp("flush", d, 16'(fl_a), 16'(e.fl));
         cmp("sel_err", d, 16'(err_a), 16'(e.err));
      end else begin
         cmp("pc", d, pc_b, e.pc);          cmp("pc_plus_1", d, pp1_b, e.pp1);
         cmp("next_pc", d, npc_b, e.npc);   cmp("link_addr", d, link_b, e.link);
         cmp("link_valid", d, 16'(lv_b), 16'(e.lv));
         cmp("flush", d, 16'(fl_b), 16'(e.fl));
         cmp("sel_err", d, 16'(err_b), 16'(e.err));
      end
   endtask

   // Monitor: observes just after every clock edge and just after an asynchronous reset assertion.
   initial begin
      exp_t e0, e1;
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         if (q0.size() > 0 && q1.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check_dut(0, e0);
            check_dut(1, e1);
         end
      end
   end

   initial begin
      model_reset(0);
      model_reset(1);

      // Reset, then three sequential fetches
      cyc(1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0);
      cyc(1'b0, 2'd0, 1'b1, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 1'b1, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0);

      // Branch and flush window, then back-to-back redirects two cycles apart
      cyc(1'b1, 2'd1, 1'b1, 16'h30F0, 16'h0, 8'h0, 1'b0, 1'b0);
      idle(4);
      cyc(1'b1, 2'd1, 1'b1, 16'h3100, 16'h0, 8'h0, 1'b0, 1'b0);
      idle(1);
      cyc(1'b1, 2'd2, 1'b1, 16'h0, 16'h3200, 8'h0, 1'b0, 1'b0);
      idle(5);

      // Link request on a plain increment is not a redirect
      cyc(1'b1, 2'd0, 1'b1, 16'h0, 16'h0, 8'h0, 1'b1, 1'b0);
      idle(1);

      // Trap with link from 3010; the trap-disabled instance flags an illegal select instead
      cyc(1'b1, 2'd2, 1'b1, 16'h0, 16'h3010, 8'h0, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b1, 16'h0, 16'h0, 8'h25, 1'b1, 1'b0);
      idle(3);
      cyc(1'b1, 2'd3, 1'b1, 16'h0, 16'h0, 8'h25, 1'b0, 1'b1);
      idle(2);
      cyc(1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0, 1'b1);
      idle(1);

      // Wrap from FFFF, then a held jump with link request
      cyc(1'b1, 2'd2, 1'b1, 16'h0, 16'hFFFF, 8'h0, 1'b0, 1'b0);
      cyc(1'b1, 2'd0, 1'b1, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 16'h0, 16'h4444, 8'h0, 1'b1, 1'b0);
      idle(4);

      // Asynchronous reset mid-flush, between edges
      cyc(1'b1, 2'd1, 1'b1, 16'h3456, 16'h0, 8'h0, 1'b1, 1'b0);
      idle(1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      push_exp();
      cyc(1'b0, 2'd2, 1'b1, 16'h0, 16'h5555, 8'h0, 1'b1, 1'b0);
      cyc(1'b1, 2'd0, 1'b1, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         logic [1:0]  s;
         logic [15:0] j;
         s = 2'($urandom_range(0, 3));
         j = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom());
         cyc(1'b1, s, ($urandom_range(0, 3) != 0), 16'($urandom()), j,
             8'($urandom()), 1'($urandom()), ($urandom_range(0, 7) == 0));
      end

      @(negedge clk);
      @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q0.size() + q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
